// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types, constants and digit helpers for the code_lock block.
// The PROGRAM state only exists when CODE_LOCK_REPROG_EN is defined.
package code_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_LOCKOUT  = 3'd3
`ifdef CODE_LOCK_REPROG_EN
    ,
    ST_PROGRAM  = 3'd4
`endif
  } state_e;

  localparam logic [1:0] PB_NONE  = 2'b00;
  localparam logic [1:0] PB_SHORT = 2'b01;
  localparam logic [1:0] PB_LONG  = 2'b10;
  localparam logic [1:0] PB_RSVD  = 2'b11;

  localparam logic [3:0] DISP_OPEN  = 4'h0;
  localparam logic [3:0] DISP_ALARM = 4'hE;

  // Codes are packed with digit 0 (first entered) in the top nibble.
  function automatic logic [15:0] set_digit(input logic [15:0] vec,
                                            input logic [1:0]  pos,
                                            input logic [3:0]  dig);
    logic [15:0] r;
    r = vec;
    case (pos)
      2'd0:    r[15:12] = dig;
      2'd1:    r[11:8]  = dig;
      2'd2:    r[7:4]   = dig;
      default: r[3:0]   = dig;
    endcase
    return r;
  endfunction

  // Selects the nibbles that take part in a compare for a len-digit code.
  function automatic logic [15:0] code_mask(input int len);
    logic [15:0] m;
    m = 16'hFFFF << (16 - 4 * len);
    return m;
  endfunction

endpackage

// File: rtl/code_lock_press_det.sv
// code_lock_press_det: turns the press-type code into single-cycle strobes.
// An event is a non-zero code following a registered zero, so both level and
// pulse inputs give exactly one strobe per press. The reserved code produces
// an event that maps to neither strobe.
module code_lock_press_det
  import code_lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pb_press_type,
  output logic       short_evt,
  output logic       long_evt
);

  logic [1:0] prev_q;
  logic [1:0] prev_d;
  logic       evt;

  // Edge detect against the previous cycle's press code.
  always_comb begin
    prev_d    = pb_press_type;
    evt       = (pb_press_type != PB_NONE) && (prev_q == PB_NONE);
    short_evt = evt && (pb_press_type == PB_SHORT);
    long_evt  = evt && (pb_press_type == PB_LONG);
  end

  // Previous press-code register.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= PB_NONE;
    else     prev_q <= prev_d;
  end

endmodule

// File: rtl/code_lock.sv
// code_lock: combination-lock controller between the encoder/pushbutton and
// the seven-segment driver. Collects CODE_LEN digits, checks them in a single
// CHECK cycle, and reports unlock, fail pulses and timed lockout.
// Optional runtime reprogramming of the code is enabled by CODE_LOCK_REPROG_EN.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] enc,
  input  logic [1:0] pb_press_type,
  output logic       unlocked,
  output logic       fail,
  output logic       alarm,
  output logic [3:0] disp_value,
  output logic [1:0] disp_sel
);

  localparam int FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1;
  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam logic [1:0]  LAST_IDX = 2'(CODE_LEN - 1);
  localparam logic [15:0] CMP_MASK = code_mask(CODE_LEN);

  logic short_evt;
  logic long_evt;

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [FW-1:0]  fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [15:0]    entry_q, entry_d;
  logic           unlocked_q, unlocked_d;
  logic           fail_q, fail_d;
  logic           alarm_q, alarm_d;
  logic [15:0]    code_cur;
  logic           code_ok;

`ifdef CODE_LOCK_REPROG_EN
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] code_q, code_d;
  assign code_cur = code_q;
`else
  assign code_cur = DEFAULT_CODE;
`endif

  code_lock_press_det u_press_det (
    .clk           (clk),
    .rst           (rst),
    .pb_press_type (pb_press_type),
    .short_evt     (short_evt),
    .long_evt      (long_evt)
  );

  // Only the overall result is used; no per-digit information leaves the block.
  assign code_ok = ((entry_q ^ code_cur) & CMP_MASK) == 16'h0;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    entry_d    = entry_q;
    fail_d     = 1'b0;
`ifdef CODE_LOCK_REPROG_EN
    shadow_d   = shadow_q;
    code_d     = code_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (short_evt) begin
          entry_d = set_digit(entry_q, idx_q, enc);
          if (idx_q == LAST_IDX) begin
            idx_d   = 2'd0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (long_evt) begin
          idx_d = 2'd0;
        end
      end
      ST_CHECK: begin
        if (code_ok) begin
          state_d    = ST_UNLOCKED;
          fail_cnt_d = '0;
        end else begin
          fail_d = 1'b1;
          if ((int'(fail_cnt_q) + 1) == MAX_FAIL) begin
            state_d = ST_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            fail_cnt_d = fail_cnt_q + FW'(1);
            state_d    = ST_ENTRY;
          end
        end
      end
      ST_UNLOCKED: begin
        if (long_evt) begin
          state_d = ST_ENTRY;
          idx_d   = 2'd0;
        end
`ifdef CODE_LOCK_REPROG_EN
        else if (short_evt) begin
          state_d = ST_PROGRAM;
          idx_d   = 2'd0;
        end
`endif
      end
      ST_LOCKOUT: begin
        // Timer runs LOCKOUT_CYCLES-1 down to 0, one state cycle per value.
        if (timer_q == '0) begin
          state_d    = ST_ENTRY;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef CODE_LOCK_REPROG_EN
      ST_PROGRAM: begin
        if (short_evt) begin
          shadow_d = set_digit(shadow_q, idx_q, enc);
          if (idx_q == LAST_IDX) begin
            code_d  = shadow_d;
            idx_d   = 2'd0;
            state_d = ST_UNLOCKED;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (long_evt) begin
          idx_d   = 2'd0;
          state_d = ST_UNLOCKED;
        end
      end
`endif
      default: begin
        state_d = ST_ENTRY;
        idx_d   = 2'd0;
      end
    endcase
`ifdef CODE_LOCK_REPROG_EN
    unlocked_d = (state_d == ST_UNLOCKED) || (state_d == ST_PROGRAM);
`else
    unlocked_d = (state_d == ST_UNLOCKED);
`endif
    alarm_d = (state_d == ST_LOCKOUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      idx_q      <= 2'd0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      entry_q    <= 16'h0;
      unlocked_q <= 1'b0;
      fail_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      entry_q    <= entry_d;
      unlocked_q <= unlocked_d;
      fail_q     <= fail_d;
      alarm_q    <= alarm_d;
    end
  end

`ifdef CODE_LOCK_REPROG_EN
  // Programmable code and its shadow; reset restores the default code.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= 16'h0;
      code_q   <= DEFAULT_CODE;
    end else begin
      shadow_q <= shadow_d;
      code_q   <= code_d;
    end
  end
`endif

  // Display mux: live encoder while digits are being entered.
  always_comb begin
    disp_value = enc;
    disp_sel   = idx_q;
    case (state_q)
      ST_UNLOCKED: begin
        disp_value = DISP_OPEN;
        disp_sel   = 2'd0;
      end
      ST_LOCKOUT: begin
        disp_value = DISP_ALARM;
        disp_sel   = 2'd0;
      end
      default: begin
        disp_value = enc;
        disp_sel   = idx_q;
      end
    endcase
  end

  assign unlocked = unlocked_q;
  assign fail     = fail_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: directed testbench for code_lock (CODE_LEN 4, code 1234,
// MAX_FAIL 3, LOCKOUT_CYCLES 20). Reprogramming scenarios are compiled in
// when CODE_LOCK_REPROG_EN is defined.
module tb_code_lock;

  localparam int LOCK_CYC = 20;

  logic       clk;
  logic       rst;
  logic [3:0] enc;
  logic [1:0] pb_press_type;
  logic       unlocked;
  logic       fail;
  logic       alarm;
  logic [3:0] disp_value;
  logic [1:0] disp_sel;

  int n_vec;
  int n_bad;
  int fail_seen;

  code_lock #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAIL       (3),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enc           (enc),
    .pb_press_type (pb_press_type),
    .unlocked      (unlocked),
    .fail          (fail),
    .alarm         (alarm),
    .disp_value    (disp_value),
    .disp_sel      (disp_sel)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts fail pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && fail) fail_seen = fail_seen + 1;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pb_press_type = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-cycle press; returns two cycles after the event cycle.
  task automatic press(input logic [3:0] d, input logic [1:0] t);
    enc = d;
    pb_press_type = t;
    tick();
    pb_press_type = 2'b00;
    tick();
  endtask

  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++) begin
      press(c[15:12], 2'b01);
      c = c << 4;
    end
  endtask

  task automatic test_reset();
    enc = 4'h7;
    do_reset();
    n_vec++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL reset_unlocked got %b want 0", unlocked); end
    n_vec++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail got %b want 0", fail); end
    n_vec++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL reset_alarm got %b want 0", alarm); end
    n_vec++; if (disp_sel !== 2'd0) begin n_bad++; $display("FAIL reset_disp_sel got %0d want 0", disp_sel); end
    n_vec++; if (disp_value !== 4'h7) begin n_bad++; $display("FAIL reset_disp_value got %h want 7", disp_value); end
  endtask

  task automatic test_unlock();
    int base;
    base = fail_seen;
    press(4'h1, 2'b01);
    press(4'h2, 2'b01);
    press(4'h3, 2'b01);
    n_vec++; if (disp_sel !== 2'd3) begin n_bad++; $display("FAIL unlock_idx3 got %0d want 3", disp_sel); end
    enc = 4'h4;
    pb_press_type = 2'b01;
    tick();
    n_vec++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL unlock_early got %b want 0", unlocked); end
    pb_press_type = 2'b00;
    tick();
    n_vec++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL unlock_latency got %b want 1", unlocked); end
    n_vec++; if (disp_value !== 4'h0) begin n_bad++; $display("FAIL unlock_disp got %h want 0", disp_value); end
    tick();
    n_vec++; if (fail_seen !== base) begin n_bad++; $display("FAIL unlock_nofail got %0d want %0d", fail_seen, base); end
    press(4'h5, 2'b10);
    n_vec++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL relock got %b want 0", unlocked); end
    n_vec++; if (disp_sel !== 2'd0) begin n_bad++; $display("FAIL relock_sel got %0d want 0", disp_sel); end
    n_vec++; if (disp_value !== 4'h5) begin n_bad++; $display("FAIL relock_disp got %h want 5", disp_value); end
  endtask

  task automatic test_wrong();
    int base;
    base = fail_seen;
    enter_code(16'h1235);
    n_vec++; if (fail !== 1'b1) begin n_bad++; $display("FAIL wrong_pulse got %b want 1", fail); end
    n_vec++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL wrong_unlocked got %b want 0", unlocked); end
    tick();
    n_vec++; if (fail !== 1'b0) begin n_bad++; $display("FAIL wrong_pulse_width got %b want 0", fail); end
    n_vec++; if (disp_sel !== 2'd0) begin n_bad++; $display("FAIL wrong_idx got %0d want 0", disp_sel); end
    tick();
    n_vec++; if (fail_seen - base !== 1) begin n_bad++; $display("FAIL wrong_count got %0d want 1", fail_seen - base); end
  endtask

  task automatic test_long_clear();
    press(4'h1, 2'b01);
    press(4'h2, 2'b01);
    n_vec++; if (disp_sel !== 2'd2) begin n_bad++; $display("FAIL clear_idx2 got %0d want 2", disp_sel); end
    press(4'h0, 2'b10);
    n_vec++; if (disp_sel !== 2'd0) begin n_bad++; $display("FAIL clear_idx0 got %0d want 0", disp_sel); end
    enc = 4'h1;
    pb_press_type = 2'b01;
    repeat (10) tick();
    pb_press_type = 2'b00;
    tick();
    n_vec++; if (disp_sel !== 2'd1) begin n_bad++; $display("FAIL held_press got %0d want 1", disp_sel); end
    press(4'h2, 2'b01);
    press(4'h3, 2'b01);
    press(4'h4, 2'b01);
    n_vec++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL clear_unlock got %b want 1", unlocked); end
  endtask

  task automatic test_lockout();
    int base;
    int cnt;
    do_reset();
    base = fail_seen;
    enter_code(16'h0000);
    n_vec++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL lock_after1 got %b want 0", alarm); end
    enter_code(16'h4321);
    n_vec++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL lock_after2 got %b want 0", alarm); end
    enter_code(16'h1235);
    n_vec++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL lock_rise got %b want 1", alarm); end
    cnt = 0;
    enc = 4'h9;
    while (alarm === 1'b1 && cnt < 100) begin
      if (cnt == 5) begin
        n_vec++; if (disp_value !== 4'hE) begin n_bad++; $display("FAIL lock_disp got %h want e", disp_value); end
      end
      pb_press_type = (cnt == 3 || cnt == 8) ? 2'b01 : ((cnt == 12) ? 2'b10 : 2'b00);
      cnt++;
      tick();
    end
    pb_press_type = 2'b00;
    n_vec++; if (cnt !== LOCK_CYC) begin n_bad++; $display("FAIL lock_len got %0d want %0d", cnt, LOCK_CYC); end
    n_vec++; if (disp_sel !== 2'd0) begin n_bad++; $display("FAIL lock_ignored got %0d want 0", disp_sel); end
    n_vec++; if (fail_seen - base !== 3) begin n_bad++; $display("FAIL lock_fails got %0d want 3", fail_seen - base); end
    enter_code(16'h1234);
    n_vec++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL lock_then_unlock got %b want 1", unlocked); end
  endtask

  task automatic test_rst_lockout();
    do_reset();
    enter_code(16'h9999);
    enter_code(16'h9999);
    enter_code(16'h9999);
    repeat (5) tick();
    n_vec++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL rstlock_alarm got %b want 1", alarm); end
    rst = 1'b1;
    tick();
    n_vec++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL rstlock_clear got %b want 0", alarm); end
    rst = 1'b0;
    tick();
    enter_code(16'h1234);
    n_vec++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL rstlock_unlock got %b want 1", unlocked); end
  endtask

`ifdef CODE_LOCK_REPROG_EN
  task automatic test_reprog();
    do_reset();
    enter_code(16'h1234);
    press(4'h0, 2'b01);
    n_vec++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL prog_unlocked got %b want 1", unlocked); end
    n_vec++; if (disp_value !== 4'h0 || disp_sel !== 2'd0) begin n_bad++; $display("FAIL prog_disp got %h/%0d want 0/0", disp_value, disp_sel); end
    enter_code(16'h9876);
    n_vec++; if (disp_value !== 4'h0) begin n_bad++; $display("FAIL prog_commit_disp got %h want 0", disp_value); end
    press(4'h0, 2'b10);
    enter_code(16'h9876);
    n_vec++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL prog_newcode got %b want 1", unlocked); end
    press(4'h0, 2'b10);
    enter_code(16'h1234);
    n_vec++; if (fail !== 1'b1) begin n_bad++; $display("FAIL prog_oldcode got %b want 1", fail); end
    enter_code(16'h9876);
    press(4'h0, 2'b01);
    press(4'h5, 2'b01);
    press(4'h5, 2'b01);
    press(4'h0, 2'b10);
    n_vec++; if (unlocked !== 1'b1 || disp_value !== 4'h0) begin n_bad++; $display("FAIL prog_abort got %b/%h want 1/0", unlocked, disp_value); end
    press(4'h0, 2'b10);
    enter_code(16'h9876);
    n_vec++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL prog_abort_code got %b want 1", unlocked); end
  endtask
`endif

  // Test sequence and final report
  initial begin
    n_vec = 0;
    n_bad = 0;
    fail_seen = 0;
    rst = 1'b1;
    enc = 4'h0;
    pb_press_type = 2'b00;
    test_reset();
    test_unlock();
    test_wrong();
    test_long_clear();
    test_lockout();
    test_rst_lockout();
`ifdef CODE_LOCK_REPROG_EN
    test_reprog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/code_lock.md
# code_lock

Combination-lock controller sitting directly downstream of the rotational encoder and upstream of the seven-segment driver. It consumes the 4-bit encoder value and the pushbutton press-type code. It collects a CODE_LEN-digit entry, compares it against a stored code, and drives unlock, fail and alarm/lockout status. It also supplies the value and digit position shown on the display.

## Interface
Parameters:
- CODE_LEN, 4: digits per code (1..4).
- DEFAULT_CODE, 16'h1234: reset code; digit 0 (first entered) in bits [15:12].
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles (>=2).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enc  in  4  live encoder digit value.
- pb_press_type  in  2  00 none, 01 short, 10 long, 11 reserved.
- unlocked  out  1  high while in UNLOCKED.
- fail  out  1  one-cycle pulse on a mismatched attempt.
- alarm  out  1  high while in LOCKOUT.
- disp_value  out  4  value for the display.
- disp_sel  out  2  digit position for the display.

## Operation
- Press event:
  - A cycle where pb_press_type != 00 and the registered previous value == 00.
  - Level or pulse inputs both yield exactly one event per press.
  - 11 produces an event that is ignored in every state.
- States are ENTRY, CHECK, UNLOCKED, LOCKOUT, plus PROGRAM (macro only).
- ENTRY:
  - Short press stores enc into entry slot idx, then idx++.
  - When the stored slot is CODE_LEN-1: idx <= 0 and go to CHECK.
  - Long press clears idx to 0; stored slots are not cleared.
- CHECK (exactly 1 cycle):
  - Compare the full entry vector against the code. Only pass or fail is revealed, never which digit mismatched.
  - Match: go to UNLOCKED; fail_cnt <= 0.
  - Mismatch: fail pulse. If fail_cnt+1 == MAX_FAIL, go to LOCKOUT and load the timer; otherwise fail_cnt++ and return to ENTRY.
- UNLOCKED: long press relocks to ENTRY with idx 0.
- LOCKOUT:
  - Timer counts down LOCKOUT_CYCLES; all events are ignored.
  - At 0: go to ENTRY, fail_cnt <= 0.
- Display:
  - ENTRY: disp_value = enc (combinational pass-through), disp_sel = idx.
  - UNLOCKED: disp_value = 4'h0, disp_sel = 0.
  - LOCKOUT: disp_value = 4'hE, disp_sel = 0.
  - CHECK: the ENTRY values held.
- All other outputs are registered.

## Timing
- Reset values: state ENTRY; idx, fail_cnt, timer, entry slots and previous-press register all 0; code = DEFAULT_CODE; unlocked, fail and alarm = 0.
- Reset mid-LOCKOUT or mid-PROGRAM aborts immediately; a reprogrammed code reverts to DEFAULT_CODE.
- The event is sampled in cycle N, the slot is written at the end of N, and idx is visible in N+1.
- Final digit in cycle N: CHECK in N+1; unlocked or fail visible in N+2.
- alarm rises in N+2 and stays high exactly LOCKOUT_CYCLES cycles.
- enc changing in the same cycle as the event: the value sampled in that cycle is stored.
- Events arriving during CHECK are dropped, not queued.
- fail_cnt saturates within 0..MAX_FAIL-1 and never wraps; idx wraps only via CHECK.

## Configuration
- CODE_LOCK_REPROG_EN defined:
  - Short press in UNLOCKED enters PROGRAM with idx 0.
  - In PROGRAM, short presses fill a shadow register slot by slot. After CODE_LEN digits, the shadow commits to the code and the block returns to UNLOCKED.
  - Long press aborts with the code unchanged and returns to UNLOCKED.
  - Display in PROGRAM: disp_value = enc, disp_sel = idx.
  - unlocked stays high in PROGRAM.
- Undefined: no PROGRAM state and no shadow register; the code is the constant DEFAULT_CODE; short press in UNLOCKED is ignored.

## Structure
- code_lock_pkg holds:
  - State enum.
  - Press-type constants PB_NONE, PB_SHORT, PB_LONG, PB_RSVD.
  - Display constants DISP_OPEN = 4'h0, DISP_ALARM = 4'hE.
- One sub-module, code_lock_press_det: registered previous press-type, emitting short_evt and long_evt single-cycle strobes.
- Lockout timer and compare stay inline.

## Test plan
- After reset, short presses with enc = 1, 2, 3, 4 -> unlocked = 1 two cycles after the 4th press; fail never pulses.
- Enter 1, 2, 3, 5 -> one fail pulse, state ENTRY, idx = 0, unlocked = 0.
- With MAX_FAIL = 3 and LOCKOUT_CYCLES = 20: three wrong codes -> alarm high for exactly 20 cycles; presses during alarm change nothing; afterwards the correct code unlocks.
- Enter 1, 2, then long press, then 1, 2, 3, 4 -> unlocks. Holding pb_press_type = 01 for 10 cycles counts as one digit.
- Unlocked, long press -> unlocked = 0, disp_sel = 0. Assert rst mid-LOCKOUT -> alarm = 0 next cycle.
- CODE_LOCK_REPROG_EN:
  - Unlock, short press, enter 9, 8, 7, 6 -> code updated; relock, then 9, 8, 7, 6 unlocks and 1, 2, 3, 4 fails.
  - Abort mid-PROGRAM with a long press -> code unchanged.
